// File: rtl/adc_fft_sequencer.sv
// Frame sequencer for the ADC -> FFT path: derives an exact 1.024 MHz sample
// strobe from the 50 MHz clock with a fractional phase accumulator. It writes
// FRAME_LEN samples into the frame buffer and launches the FFT. It then waits
// for the FFT to finish before the buffer is reused.
// Optional feature: define SEQ_CONTINUOUS_EN for back-to-back frames without a new start.
module adc_fft_sequencer #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ACC_INC   = 128,
    parameter int unsigned ACC_MOD   = 6250
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              fft_done_i,
    output logic              sample_tick_o,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    output logic              fft_start_o,
    output logic              fft_flag_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int unsigned AccW = $clog2(ACC_MOD + ACC_INC);

    typedef enum logic [1:0] {StIdle, StCapture, StLaunch, StWaitFft} state_e;

    state_e              state_q, state_d;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [AccW-1:0]     acc_sum;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                tick;

    logic                sample_tick_q, buf_we_q, fft_start_q, fft_flag_q, busy_q;
    logic [ADDR_W-1:0]   buf_addr_q;
    logic [DATA_W-1:0]   buf_wdata_q;

`ifdef SEQ_CONTINUOUS_EN
    // Stop seen while the FFT owns the buffer; honoured at fft_done.
    logic                stop_pend_q, stop_pend_d;
`endif

    assign acc_sum = acc_q + AccW'(ACC_INC);

    // Next-state logic: capture timing, address generation and frame handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wr_addr_d   = wr_addr_q;
        frame_cnt_d = frame_cnt_q;
        tick        = 1'b0;
`ifdef SEQ_CONTINUOUS_EN
        stop_pend_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d   = StCapture;
                    acc_d     = '0;
                    wr_addr_d = '0;
                end
            end
            StCapture: begin
                if (stop_i) begin
                    // Abort discards the partial frame and suppresses a coincident tick.
                    state_d = StIdle;
                end else if (acc_sum >= AccW'(ACC_MOD)) begin
                    acc_d     = acc_sum - AccW'(ACC_MOD);
                    tick      = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == ADDR_W'(FRAME_LEN - 1)) begin
                        state_d = StLaunch;
                    end
                end else begin
                    acc_d = acc_sum;
                end
            end
            StLaunch: begin
                state_d = StWaitFft;
            end
            StWaitFft: begin
`ifdef SEQ_CONTINUOUS_EN
                stop_pend_d = stop_pend_q | stop_i;
`endif
                if (fft_done_i) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef SEQ_CONTINUOUS_EN
                    if (stop_pend_d) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StCapture;
                        acc_d     = '0;
                        wr_addr_d = '0;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; everything clears asynchronously on reset.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            wr_addr_q     <= '0;
            frame_cnt_q   <= '0;
            sample_tick_q <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            fft_start_q   <= 1'b0;
            fft_flag_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SEQ_CONTINUOUS_EN
            stop_pend_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            wr_addr_q     <= wr_addr_d;
            frame_cnt_q   <= frame_cnt_d;
            sample_tick_q <= tick;
            buf_we_q      <= tick;
            if (tick) begin
                buf_addr_q  <= wr_addr_q;
                buf_wdata_q <= adc_data_i;
            end
            fft_start_q   <= (state_q == StLaunch);
            fft_flag_q    <= (state_d == StWaitFft);
            busy_q        <= (state_d != StIdle);
`ifdef SEQ_CONTINUOUS_EN
            stop_pend_q   <= stop_pend_d;
`endif
        end
    end

    assign sample_tick_o = sample_tick_q;
    assign buf_we_o      = buf_we_q;
    assign buf_addr_o    = buf_addr_q;
    assign buf_wdata_o   = buf_wdata_q;
    assign fft_start_o   = fft_start_q;
    assign fft_flag_o    = fft_flag_q;
    assign busy_o        = busy_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
